// File: rtl/apb_master_bridge_pkg.sv
// apb_master_bridge_pkg
// Shared types and constants for the APB master bridge:
//   state_t  - bridge FSM states (IDLE/SETUP/ACCESS/RESP)
//   rsp_t    - response payload {rdata, err, timeout}
//   err_rsp  - builds an error response with zero read data
package apb_master_bridge_pkg;

    localparam int SLV_IDX_WIDTH  = 4;
    localparam int PSEL_WIDTH     = 16;
    localparam int RSP_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef struct packed {
        logic [RSP_DATA_WIDTH-1:0] rdata;
        logic                      err;
        logic                      timeout;
    } rsp_t;

    function automatic rsp_t err_rsp(input logic timeout);
        rsp_t r;
        r.rdata   = '0;
        r.err     = 1'b1;
        r.timeout = timeout;
        return r;
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if
// Bundles the command, response and APB signals of the bridge.
//   master modport : the bridge's view (drives req_ready, rsp_*, APB outputs)
//   slave modport  : the environment's view (command source, response sink,
//                    APB slave)
interface apb_master_bridge_if
    import apb_master_bridge_pkg::*;
#(
    parameter int PADDR_WIDTH  = 32,
    parameter int PWDATA_WIDTH = 32,
    parameter int PRDATA_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic [PADDR_WIDTH-1:0]  req_addr;
    logic                    req_write;
    logic [PWDATA_WIDTH-1:0] req_wdata;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [PRDATA_WIDTH-1:0] rsp_rdata;
    logic                    rsp_err;
    logic                    rsp_timeout;

    logic [PADDR_WIDTH-1:0]  paddr;
    logic                    prwd;
    logic [PWDATA_WIDTH-1:0] pwdata;
    logic                    penable;
    logic [PSEL_WIDTH-1:0]   psel;
    logic [PRDATA_WIDTH-1:0] prdata;
    logic                    pslverr;
    logic                    pready;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata, rsp_ready,
               prdata, pslverr, pready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               paddr, prwd, pwdata, penable, psel
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata, rsp_ready,
               prdata, pslverr, pready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               paddr, prwd, pwdata, penable, psel
    );

endinterface

// File: rtl/apb_psel_decoder.sv
// apb_psel_decoder
// Turns the slave-index field of an address into a one-hot 16-bit select.
// Indices at or above NUM_SLAVES give an all-zero select and dec_err=1.
//   idx     in   slave index field of the address
//   sel     out  one-hot select (zero on decode error)
//   dec_err out  index not populated
module apb_psel_decoder
    import apb_master_bridge_pkg::*;
#(
    parameter int NUM_SLAVES = 16
) (
    input  logic [SLV_IDX_WIDTH-1:0] idx,
    output logic [PSEL_WIDTH-1:0]    sel,
    output logic                     dec_err
);
    // One extra bit so NUM_SLAVES=16 is representable.
    localparam logic [SLV_IDX_WIDTH:0] NUM_SLV = (SLV_IDX_WIDTH+1)'(NUM_SLAVES);

    always_comb begin
        sel     = '0;
        dec_err = ({1'b0, idx} >= NUM_SLV);
        if (!dec_err) begin
            sel[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// Converts a valid/ready command stream into single APB SETUP/ACCESS
// transfers and returns {rdata, err, timeout} on a valid/ready response
// channel. One transfer outstanding at a time.
//   pclock  in  APB clock
//   preset  in  asynchronous reset, active-high
//   bus     master modport of apb_master_bridge_if (command, response, APB)
// Optional build macro APB_MASTER_BRIDGE_TIMEOUT_EN: enables the ACCESS
// wait-state counter and abort path; without it ACCESS waits for pready
// indefinitely and rsp_timeout is always 0.
module apb_master_bridge
    import apb_master_bridge_pkg::*;
#(
    parameter int PADDR_WIDTH    = 32,
    parameter int PWDATA_WIDTH   = 32,
    parameter int PRDATA_WIDTH   = 32,
    parameter int NUM_SLAVES     = 16,
    parameter int SLV_ADDR_LSB   = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 pclock,
    input  logic                 preset,
    apb_master_bridge_if.master  bus
);

    if (TIMEOUT_CYCLES < 2 || NUM_SLAVES < 1 || NUM_SLAVES > PSEL_WIDTH ||
        PRDATA_WIDTH > RSP_DATA_WIDTH) begin : g_bad_cfg
        $error("apb_master_bridge: unsupported parameter set");
    end

    state_t                  state, state_nxt;
    logic                    ready_en;
    logic [PADDR_WIDTH-1:0]  addr_q;
    logic                    write_q;
    logic [PWDATA_WIDTH-1:0] wdata_q;
    logic [PSEL_WIDTH-1:0]   sel_q;
    rsp_t                    rsp_q, rsp_nxt;

    logic [PSEL_WIDTH-1:0]   dec_sel;
    logic                    dec_err;
    logic                    accept;
    logic                    timeout_hit;

    apb_psel_decoder #(
        .NUM_SLAVES (NUM_SLAVES)
    ) u_dec (
        .idx     (bus.req_addr[SLV_ADDR_LSB+SLV_IDX_WIDTH-1:SLV_ADDR_LSB]),
        .sel     (dec_sel),
        .dec_err (dec_err)
    );

    assign accept = (state == IDLE) && ready_en && bus.req_valid;

`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] wait_cnt;

    // Counter holds the number of ACCESS cycles already spent without pready.
    assign timeout_hit = (state == ACCESS) && !bus.pready &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge pclock or posedge preset) begin
        if (preset) begin
            wait_cnt <= '0;
        end else if (state == RESP && bus.rsp_ready) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !bus.pready && !timeout_hit) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        rsp_nxt   = rsp_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (dec_err) begin
                        state_nxt = RESP;
                        rsp_nxt   = err_rsp(1'b0);
                    end else begin
                        state_nxt = SETUP;
                    end
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                // pready wins over a timeout in the same cycle.
                if (bus.pready) begin
                    state_nxt       = RESP;
                    rsp_nxt.err     = bus.pslverr;
                    rsp_nxt.timeout = 1'b0;
                    rsp_nxt.rdata   = (write_q || bus.pslverr) ? '0
                                      : RSP_DATA_WIDTH'(bus.prdata);
                end else if (timeout_hit) begin
                    state_nxt = RESP;
                    rsp_nxt   = err_rsp(1'b1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclock or posedge preset) begin
        if (preset) begin
            state    <= IDLE;
            ready_en <= 1'b0;
            rsp_q    <= '0;
        end else begin
            state    <= state_nxt;
            ready_en <= 1'b1;
            rsp_q    <= rsp_nxt;
        end
    end

    // Command is captured only for decodable addresses so a decode error
    // leaves the APB address/data lines untouched.
    always_ff @(posedge pclock or posedge preset) begin
        if (preset) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            sel_q   <= '0;
        end else if (accept && !dec_err) begin
            addr_q  <= bus.req_addr;
            write_q <= bus.req_write;
            wdata_q <= bus.req_wdata;
            sel_q   <= dec_sel;
        end
    end

    assign bus.req_ready   = (state == IDLE) && ready_en;
    assign bus.rsp_valid   = (state == RESP);
    assign bus.rsp_rdata   = rsp_q.rdata[PRDATA_WIDTH-1:0];
    assign bus.rsp_err     = rsp_q.err;
    assign bus.rsp_timeout = rsp_q.timeout;

    assign bus.psel    = (state == SETUP || state == ACCESS) ? sel_q : '0;
    assign bus.penable = (state == ACCESS);
    assign bus.paddr   = addr_q;
    assign bus.prwd    = write_q;
    assign bus.pwdata  = wdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
// Directed bench for apb_master_bridge with NUM_SLAVES=4, TIMEOUT_CYCLES=8.
// Inputs are driven and outputs sampled 1 ns after the rising edge.
module tb_apb_master_bridge;
    import apb_master_bridge_pkg::*;

    logic pclock;
    logic preset;
    int   total;
    int   bad;

    apb_master_bridge_if #(
        .PADDR_WIDTH(32), .PWDATA_WIDTH(32), .PRDATA_WIDTH(32)
    ) bus ();

    apb_master_bridge #(
        .PADDR_WIDTH(32), .PWDATA_WIDTH(32), .PRDATA_WIDTH(32),
        .NUM_SLAVES(4), .SLV_ADDR_LSB(12), .TIMEOUT_CYCLES(8)
    ) dut (
        .pclock (pclock),
        .preset (preset),
        .bus    (bus)
    );

    initial pclock = 1'b0;
    always #5 pclock = ~pclock;

    task automatic tick();
        @(posedge pclock);
        #1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wd);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_write = wr;
        bus.req_wdata = wd;
    endtask

    task automatic test_reset();
        preset        = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_write = 1'b0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.prdata    = '0;
        bus.pslverr   = 1'b0;
        bus.pready    = 1'b0;
        tick();
        tick();
        total++; if (bus.psel !== 16'h0) begin bad++; $display("FAIL rst_psel got=%h exp=%h", bus.psel, 16'h0); end
        total++; if (bus.penable !== 1'b0) begin bad++; $display("FAIL rst_penable got=%b exp=0", bus.penable); end
        total++; if (bus.paddr !== 32'h0) begin bad++; $display("FAIL rst_paddr got=%h exp=0", bus.paddr); end
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", bus.rsp_valid); end
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%b exp=0", bus.req_ready); end
        total++; if ({bus.rsp_err, bus.rsp_timeout} !== 2'b00) begin bad++; $display("FAIL rst_rsp_flags got=%b exp=00", {bus.rsp_err, bus.rsp_timeout}); end
        preset = 1'b0;
        #1;
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL rel_req_ready got=%b exp=0", bus.req_ready); end
        tick();
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL post_rel_req_ready got=%b exp=1", bus.req_ready); end
    endtask

    task automatic test_zero_wait_write();
        issue(32'h0000_1004, 1'b1, 32'hA5A5_0001);
        bus.pready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        total++; if (bus.psel !== 16'h0002 || bus.penable !== 1'b0) begin bad++; $display("FAIL zw_setup psel/en got=%h/%b exp=0002/0", bus.psel, bus.penable); end
        total++; if (bus.paddr !== 32'h0000_1004 || bus.prwd !== 1'b1 || bus.pwdata !== 32'hA5A5_0001) begin bad++; $display("FAIL zw_setup_bus got=%h/%b/%h exp=00001004/1/a5a50001", bus.paddr, bus.prwd, bus.pwdata); end
        tick();
        total++; if (bus.psel !== 16'h0002 || bus.penable !== 1'b1) begin bad++; $display("FAIL zw_access psel/en got=%h/%b exp=0002/1", bus.psel, bus.penable); end
        total++; if (bus.paddr !== 32'h0000_1004 || bus.pwdata !== 32'hA5A5_0001) begin bad++; $display("FAIL zw_access_bus got=%h/%h exp=00001004/a5a50001", bus.paddr, bus.pwdata); end
        tick();
        total++; if (bus.rsp_valid !== 1'b1 || bus.psel !== 16'h0 || bus.penable !== 1'b0) begin bad++; $display("FAIL zw_resp got=%b/%h/%b exp=1/0000/0", bus.rsp_valid, bus.psel, bus.penable); end
        total++; if (bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.req_ready !== 1'b0) begin bad++; $display("FAIL zw_payload got=%b/%h/%b exp=0/00000000/0", bus.rsp_err, bus.rsp_rdata, bus.req_ready); end
        total++; if (bus.paddr !== 32'h0000_1004) begin bad++; $display("FAIL zw_resp_paddr got=%h exp=00001004", bus.paddr); end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        total++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin bad++; $display("FAIL zw_idle got=%b/%b exp=0/1", bus.rsp_valid, bus.req_ready); end
    endtask

    task automatic test_read_wait();
        issue(32'h0000_3010, 1'b0, 32'h0);
        bus.pready = 1'b0;
        bus.prdata = 32'hDEAD_BEEF;
        tick();
        bus.req_valid = 1'b0;
        total++; if (bus.psel !== 16'h0008 || bus.prwd !== 1'b0) begin bad++; $display("FAIL rw_setup got=%h/%b exp=0008/0", bus.psel, bus.prwd); end
        tick();
        for (int i = 1; i <= 3; i++) begin
            total++; if (bus.penable !== 1'b1 || bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rw_wait%0d got=%b/%b exp=1/0", i, bus.penable, bus.rsp_valid); end
            tick();
        end
        bus.pready = 1'b1;
        total++; if (bus.penable !== 1'b1 || bus.psel !== 16'h0008) begin bad++; $display("FAIL rw_access4 got=%b/%h exp=1/0008", bus.penable, bus.psel); end
        tick();
        total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rw_resp got=%b/%h exp=1/deadbeef", bus.rsp_valid, bus.rsp_rdata); end
        total++; if (bus.rsp_err !== 1'b0 || bus.rsp_timeout !== 1'b0) begin bad++; $display("FAIL rw_flags got=%b/%b exp=0/0", bus.rsp_err, bus.rsp_timeout); end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_slave_error();
        issue(32'h0000_0040, 1'b0, 32'h0);
        bus.pready  = 1'b1;
        bus.pslverr = 1'b1;
        bus.prdata  = 32'h0000_CAFE;
        tick();
        bus.req_valid = 1'b0;
        total++; if (bus.psel !== 16'h0001) begin bad++; $display("FAIL se_psel got=%h exp=0001", bus.psel); end
        tick();
        tick();
        bus.pslverr = 1'b0;
        total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_timeout !== 1'b0) begin bad++; $display("FAIL se_resp got=%b/%b/%b exp=1/1/0", bus.rsp_valid, bus.rsp_err, bus.rsp_timeout); end
        total++; if (bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL se_rdata got=%h exp=00000000", bus.rsp_rdata); end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_decode_error();
        issue(32'h0000_5000, 1'b1, 32'h1111_2222);
        bus.pready = 1'b1;
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL de_req_ready got=%b exp=1", bus.req_ready); end
        tick();
        bus.req_valid = 1'b0;
        total++; if (bus.psel !== 16'h0 || bus.penable !== 1'b0) begin bad++; $display("FAIL de_no_apb got=%h/%b exp=0000/0", bus.psel, bus.penable); end
        total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0 || bus.rsp_timeout !== 1'b0) begin bad++; $display("FAIL de_resp got=%b/%b/%h/%b exp=1/1/00000000/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.rsp_timeout); end
        total++; if (bus.paddr !== 32'h0000_0040) begin bad++; $display("FAIL de_paddr got=%h exp=00000040", bus.paddr); end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        issue(32'h0000_2000, 1'b0, 32'h0);
        bus.pready = 1'b1;
        bus.prdata = 32'h1234_5678;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        bus.prdata = 32'hFFFF_0000;
        issue(32'h0000_1000, 1'b1, 32'h9999_9999);
        for (int i = 0; i < 5; i++) begin
            total++; if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.rsp_rdata !== 32'h1234_5678 || bus.rsp_err !== 1'b0) begin bad++; $display("FAIL bp_hold%0d got=%b/%b/%h/%b exp=1/0/12345678/0", i, bus.rsp_valid, bus.req_ready, bus.rsp_rdata, bus.rsp_err); end
            total++; if (bus.psel !== 16'h0 || bus.paddr !== 32'h0000_2000) begin bad++; $display("FAIL bp_bus%0d got=%h/%h exp=0000/00002000", i, bus.psel, bus.paddr); end
            tick();
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        issue(32'h0000_1000, 1'b1, 32'h0000_00AA);
        bus.pready = 1'b1;
        tick();
        tick();
        tick();
        issue(32'h0000_3000, 1'b1, 32'h0000_00BB);
        total++; if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0) begin bad++; $display("FAIL b2b_resp got=%b/%b exp=1/0", bus.rsp_valid, bus.req_ready); end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        total++; if (bus.req_ready !== 1'b1 || bus.psel !== 16'h0) begin bad++; $display("FAIL b2b_idle got=%b/%h exp=1/0000", bus.req_ready, bus.psel); end
        tick();
        bus.req_valid = 1'b0;
        total++; if (bus.psel !== 16'h0008 || bus.pwdata !== 32'h0000_00BB) begin bad++; $display("FAIL b2b_setup2 got=%h/%h exp=0008/000000bb", bus.psel, bus.pwdata); end
        tick();
        tick();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        issue(32'h0000_1000, 1'b0, 32'h0);
        bus.pready = 1'b0;
        bus.prdata = 32'h5555_AAAA;
        tick();
        bus.req_valid = 1'b0;
        tick();
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
        for (int i = 2; i <= 8; i++) begin
            tick();
            total++; if (bus.penable !== 1'b1 || bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL to_access%0d got=%b/%b exp=1/0", i, bus.penable, bus.rsp_valid); end
        end
        tick();
        total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_timeout !== 1'b1) begin bad++; $display("FAIL to_abort got=%b/%b/%b exp=1/1/1", bus.rsp_valid, bus.rsp_err, bus.rsp_timeout); end
        total++; if (bus.psel !== 16'h0 || bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL to_abort_bus got=%h/%h exp=0000/00000000", bus.psel, bus.rsp_rdata); end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        // pready arriving on the limit cycle completes normally
        issue(32'h0000_1000, 1'b0, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        tick();
        for (int i = 2; i <= 8; i++) tick();
        bus.pready = 1'b1;
        tick();
        total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_timeout !== 1'b0 || bus.rsp_rdata !== 32'h5555_AAAA) begin bad++; $display("FAIL to_limit_pready got=%b/%b/%b/%h exp=1/0/0/5555aaaa", bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata); end
`else
        for (int i = 0; i < 100; i++) tick();
        total++; if (bus.penable !== 1'b1 || bus.psel !== 16'h0002 || bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL to_still_waiting got=%b/%h/%b exp=1/0002/0", bus.penable, bus.psel, bus.rsp_valid); end
        bus.pready = 1'b1;
        tick();
        total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_timeout !== 1'b0 || bus.rsp_rdata !== 32'h5555_AAAA) begin bad++; $display("FAIL to_late_pready got=%b/%b/%h exp=1/0/5555aaaa", bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata); end
`endif
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        issue(32'h0000_1000, 1'b1, 32'h0000_0077);
        bus.pready = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        tick();
        total++; if (bus.penable !== 1'b1) begin bad++; $display("FAIL rm_in_access got=%b exp=1", bus.penable); end
        preset = 1'b1;
        #1;
        total++; if (bus.psel !== 16'h0 || bus.penable !== 1'b0 || bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rm_async got=%h/%b/%b exp=0000/0/0", bus.psel, bus.penable, bus.rsp_valid); end
        bus.pready = 1'b1;
        tick();
        preset = 1'b0;
        #1;
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL rm_rel_ready got=%b exp=0", bus.req_ready); end
        tick();
        total++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.psel !== 16'h0) begin bad++; $display("FAIL rm_idle got=%b/%b/%h exp=1/0/0000", bus.req_ready, bus.rsp_valid, bus.psel); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_zero_wait_write();
        test_read_wait();
        test_slave_error();
        test_decode_error();
        test_backpressure();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
